shotclock_ctrl: RTL and testbench

- Sequencing controller for the shot-clock datapath: owns the BCD countdown counter's load and tick inputs, and drives the horn and display-blink controls.
- Sits between the debounced button pulses, the 1 Hz tick from the clock divider, and the bcd_counter / sevenseg_mux pair.
- Implements run, pause, full/short reset, expiry horn and hold-at-zero.

---
 rtl/shotclock_pkg.sv | 17 +
 rtl/shotclock_horn_timer.sv | 37 +++
 rtl/shotclock_ctrl.sv | 140 ++++++++++++++
 tb/tb_shotclock_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/shotclock_pkg.sv
// Shared definitions for the shot-clock controller: state encoding and BCD presets.
package shotclock_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RUN     = 3'd1,
      PAUSE   = 3'd2,
      EXPIRED = 3'd3,
      HOLD    = 3'd4
   } state_t;

   localparam logic [3:0] PRESET_FULL_S1  = 4'd2;
   localparam logic [3:0] PRESET_FULL_S0  = 4'd4;
   localparam logic [3:0] PRESET_SHORT_S1 = 4'd1;
   localparam logic [3:0] PRESET_SHORT_S0 = 4'd4;

endpackage

// File: rtl/shotclock_horn_timer.sv
// Counts 1 Hz ticks after expiry; once the horn period is over, toggles the blink phase per tick.
module shotclock_horn_timer #(
   parameter int HORN_TICKS = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic tick_1hz,
   output logic done,
   output logic blink
);

   localparam logic [3:0] LAST = 4'(HORN_TICKS);

   logic [3:0] cnt_reg;
   logic       blink_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg   <= 4'd0;
         blink_reg <= 1'b0;
      end else if (clear) begin
         cnt_reg   <= 4'd0;
         blink_reg <= 1'b0;
      end else if (tick_1hz) begin
         if (cnt_reg == LAST)
            blink_reg <= ~blink_reg;
         else
            cnt_reg <= cnt_reg + 4'd1;
      end
   end

   // Look-ahead so the controller can silence the horn on the very tick that completes the period.
   assign done  = (cnt_reg == LAST) || (tick_1hz && (cnt_reg == LAST - 4'd1));
   assign blink = blink_reg;

endmodule

// File: rtl/shotclock_ctrl.sv
// Shot-clock sequencing FSM: drives load/preset and gated tick into the BCD counter, plus horn and blank.
module shotclock_ctrl
   import shotclock_pkg::*;
#(
   parameter logic [3:0] FULL_S1    = PRESET_FULL_S1,
   parameter logic [3:0] FULL_S0    = PRESET_FULL_S0,
   parameter logic [3:0] SHORT_S1   = PRESET_SHORT_S1,
   parameter logic [3:0] SHORT_S0   = PRESET_SHORT_S0,
   parameter int         HORN_TICKS = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_pulse,
   input  logic       pause_pulse,
   input  logic       full_pulse,
   input  logic       short_pulse,
   input  logic       tick_1hz,
   input  logic       zero,
   output logic       load,
   output logic [3:0] preset_s1,
   output logic [3:0] preset_s0,
   output logic       cnt_tick,
   output logic       horn,
   output logic       blank,
   output logic [2:0] state_o
);

   state_t     state_reg;
   logic       load_reg;
   logic [3:0] preset_s1_reg;
   logic [3:0] preset_s0_reg;
   logic       cnt_tick_reg;
   logic       horn_reg;
   logic       guard_reg;
   logic       init_done_reg;
   logic       horn_done;
   logic       horn_blink;
   logic       timer_clear;

   // Timer runs only while in EXPIRED/HOLD and is wiped on the same edge that leaves them.
   assign timer_clear = !(state_reg == EXPIRED || state_reg == HOLD)
                        || full_pulse || short_pulse || start_pulse;

   shotclock_horn_timer #(
      .HORN_TICKS (HORN_TICKS)
   ) u_horn_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (timer_clear),
      .tick_1hz (tick_1hz),
      .done     (horn_done),
      .blink    (horn_blink)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         load_reg      <= 1'b0;
         preset_s1_reg <= FULL_S1;
         preset_s0_reg <= FULL_S0;
         cnt_tick_reg  <= 1'b0;
         horn_reg      <= 1'b0;
         guard_reg     <= 1'b0;
         init_done_reg <= 1'b0;
      end else begin
         load_reg     <= 1'b0;
         guard_reg    <= 1'b0;
         cnt_tick_reg <= 1'b0;
         if (!init_done_reg) begin
            init_done_reg <= 1'b1;
            load_reg      <= 1'b1;
            guard_reg     <= 1'b1;
            preset_s1_reg <= FULL_S1;
            preset_s0_reg <= FULL_S0;
         end else if (full_pulse || short_pulse) begin
            load_reg      <= 1'b1;
            guard_reg     <= 1'b1;
            preset_s1_reg <= full_pulse ? FULL_S1 : SHORT_S1;
            preset_s0_reg <= full_pulse ? FULL_S0 : SHORT_S0;
            horn_reg      <= 1'b0;
            state_reg     <= (state_reg == RUN) ? RUN : IDLE;
         end else begin
            case (state_reg)
               IDLE, PAUSE: begin
                  if (start_pulse) begin
                     state_reg    <= RUN;
                     cnt_tick_reg <= tick_1hz;
                  end
               end
               RUN: begin
                  // guard masks the stale zero seen while the counter is still absorbing a load
                  if (pause_pulse && !start_pulse) begin
                     state_reg <= PAUSE;
                  end else if (zero && !guard_reg) begin
                     state_reg <= EXPIRED;
                     horn_reg  <= 1'b1;
                  end else begin
                     cnt_tick_reg <= tick_1hz;
                  end
               end
               EXPIRED: begin
                  if (start_pulse) begin
                     state_reg     <= RUN;
                     load_reg      <= 1'b1;
                     guard_reg     <= 1'b1;
                     preset_s1_reg <= FULL_S1;
                     preset_s0_reg <= FULL_S0;
                     horn_reg      <= 1'b0;
                  end else if (horn_done) begin
                     state_reg <= HOLD;
                     horn_reg  <= 1'b0;
                  end
               end
               HOLD: begin
                  if (start_pulse) begin
                     state_reg     <= RUN;
                     load_reg      <= 1'b1;
                     guard_reg     <= 1'b1;
                     preset_s1_reg <= FULL_S1;
                     preset_s0_reg <= FULL_S0;
                  end
               end
               default: begin
                  state_reg <= IDLE;
                  horn_reg  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign load      = load_reg;
   assign preset_s1 = preset_s1_reg;
   assign preset_s0 = preset_s0_reg;
   assign cnt_tick  = cnt_tick_reg;
   assign horn      = horn_reg;
   assign blank     = horn_blink;
   assign state_o   = state_reg;

endmodule

// File: tb/tb_shotclock_ctrl.sv
// Directed bench for shotclock_ctrl with a behavioural BCD counter closing the load/tick/zero loop.
module tb_shotclock_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_pulse, pause_pulse, full_pulse, short_pulse, tick_1hz;
   logic       zero;
   logic       load, cnt_tick, horn, blank;
   logic [3:0] preset_s1, preset_s0;
   logic [2:0] state_o;

   int tests_run    = 0;
   int tests_failed = 0;
   int cnt_val      = 0;

   shotclock_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_pulse (start_pulse),
      .pause_pulse (pause_pulse),
      .full_pulse  (full_pulse),
      .short_pulse (short_pulse),
      .tick_1hz    (tick_1hz),
      .zero        (zero),
      .load        (load),
      .preset_s1   (preset_s1),
      .preset_s0   (preset_s0),
      .cnt_tick    (cnt_tick),
      .horn        (horn),
      .blank       (blank),
      .state_o     (state_o)
   );

   always #5 clk = ~clk;

   // Counter model: load wins, otherwise count down and hold at 00.
   always @(posedge clk) begin
      if (load)
         cnt_val <= 10 * int'(preset_s1) + int'(preset_s0);
      else if (cnt_tick && cnt_val > 0)
         cnt_val <= cnt_val - 1;
   end
   assign zero = (cnt_val == 0);

   // Drive one cycle of inputs at a negedge; returns at the next negedge with outputs settled.
   task automatic step(input logic s, input logic p, input logic f, input logic sh, input logic t);
      start_pulse = s; pause_pulse = p; full_pulse = f; short_pulse = sh; tick_1hz = t;
      @(negedge clk);
      start_pulse = 0; pause_pulse = 0; full_pulse = 0; short_pulse = 0; tick_1hz = 0;
   endtask

   task automatic run_tick(input logic exp_tick, input string tag);
      step(0, 0, 0, 0, 1);
      tests_run++; if (cnt_tick !== exp_tick) begin tests_failed++; $display("FAIL %s cnt_tick: got %b want %b", tag, cnt_tick, exp_tick); end
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
   endtask

   task automatic test_reset;
      rst_n = 0; start_pulse = 0; pause_pulse = 0; full_pulse = 0; short_pulse = 0; tick_1hz = 0;
      repeat (2) @(negedge clk);
      tests_run++; if ({load, horn, blank, cnt_tick} !== 4'b0000) begin tests_failed++; $display("FAIL rst_outs: got %b want 0000", {load, horn, blank, cnt_tick}); end
      tests_run++; if ({preset_s1, preset_s0} !== 8'h24) begin tests_failed++; $display("FAIL rst_preset: got %h want 24", {preset_s1, preset_s0}); end
      tests_run++; if (state_o !== 3'd0) begin tests_failed++; $display("FAIL rst_state: got %0d want 0", state_o); end
      rst_n = 1;
      @(negedge clk);
      tests_run++; if (load !== 1'b1 || {preset_s1, preset_s0} !== 8'h24) begin tests_failed++; $display("FAIL init_load: got load=%b preset=%h want 1/24", load, {preset_s1, preset_s0}); end
      tests_run++; if (state_o !== 3'd0 || horn !== 1'b0) begin tests_failed++; $display("FAIL init_state: got state=%0d horn=%b want 0/0", state_o, horn); end
      @(negedge clk);
      tests_run++; if (load !== 1'b0 || cnt_val !== 24) begin tests_failed++; $display("FAIL init_count: got load=%b cnt=%0d want 0/24", load, cnt_val); end
      $display("[TB] reset: state=%0d count=%0d", state_o, cnt_val);
   endtask

   task automatic test_run;
      step(1, 0, 0, 0, 0);
      tests_run++; if (state_o !== 3'd1 || load !== 1'b0) begin tests_failed++; $display("FAIL run_start: got state=%0d load=%b want 1/0", state_o, load); end
      repeat (3) run_tick(1, "run");
      tests_run++; if (cnt_val !== 21) begin tests_failed++; $display("FAIL run_count: got %0d want 21", cnt_val); end
      $display("[TB] run: count=%0d", cnt_val);
   endtask

   task automatic test_pause;
      step(0, 1, 0, 0, 0);
      tests_run++; if (state_o !== 3'd2) begin tests_failed++; $display("FAIL pause_state: got %0d want 2", state_o); end
      repeat (5) run_tick(0, "pause");
      tests_run++; if (cnt_val !== 21) begin tests_failed++; $display("FAIL pause_hold: got %0d want 21", cnt_val); end
      step(1, 0, 0, 0, 0);
      tests_run++; if (state_o !== 3'd1 || load !== 1'b0) begin tests_failed++; $display("FAIL resume: got state=%0d load=%b want 1/0", state_o, load); end
      run_tick(1, "resume");
      tests_run++; if (cnt_val !== 20) begin tests_failed++; $display("FAIL resume_count: got %0d want 20", cnt_val); end
      $display("[TB] pause/resume: count=%0d", cnt_val);
   endtask

   task automatic test_short_with_tick;
      repeat (13) run_tick(1, "to07");
      tests_run++; if (cnt_val !== 7) begin tests_failed++; $display("FAIL count07: got %0d want 7", cnt_val); end
      step(0, 0, 0, 1, 1);
      tests_run++; if (load !== 1'b1 || {preset_s1, preset_s0} !== 8'h14) begin tests_failed++; $display("FAIL short_load: got load=%b preset=%h want 1/14", load, {preset_s1, preset_s0}); end
      tests_run++; if (cnt_tick !== 1'b0 || state_o !== 3'd1) begin tests_failed++; $display("FAIL short_gate: got tick=%b state=%0d want 0/1", cnt_tick, state_o); end
      step(0, 0, 0, 0, 0);
      tests_run++; if (cnt_val !== 14) begin tests_failed++; $display("FAIL short_count: got %0d want 14", cnt_val); end
      run_tick(1, "after_short");
      tests_run++; if (cnt_val !== 13) begin tests_failed++; $display("FAIL short_next: got %0d want 13", cnt_val); end
      $display("[TB] short reload with tick: count=%0d", cnt_val);
   endtask

   task automatic test_expiry;
      repeat (13) run_tick(1, "to00");
      tests_run++; if (state_o !== 3'd3 || horn !== 1'b1 || cnt_val !== 0) begin tests_failed++; $display("FAIL expire: got state=%0d horn=%b cnt=%0d want 3/1/0", state_o, horn, cnt_val); end
      for (int i = 1; i <= 3; i++) begin
         step(0, 0, 0, 0, 1);
         tests_run++; if (horn !== (i < 3) || state_o !== ((i < 3) ? 3'd3 : 3'd4)) begin tests_failed++; $display("FAIL horn_tick%0d: got horn=%b state=%0d", i, horn, state_o); end
         step(0, 0, 0, 0, 0);
      end
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 1);
         tests_run++; if (blank !== ((i % 2) == 0) || cnt_tick !== 1'b0) begin tests_failed++; $display("FAIL blink%0d: got blank=%b tick=%b want %b/0", i, blank, cnt_tick, (i % 2) == 0); end
         step(0, 0, 0, 0, 0);
      end
      step(1, 0, 0, 0, 0);
      tests_run++; if (load !== 1'b1 || {preset_s1, preset_s0} !== 8'h24 || state_o !== 3'd1) begin tests_failed++; $display("FAIL hold_start: got load=%b preset=%h state=%0d want 1/24/1", load, {preset_s1, preset_s0}, state_o); end
      tests_run++; if (blank !== 1'b0 || horn !== 1'b0) begin tests_failed++; $display("FAIL hold_start_outs: got blank=%b horn=%b want 0/0", blank, horn); end
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      tests_run++; if (state_o !== 3'd1 || cnt_val !== 24) begin tests_failed++; $display("FAIL guard: got state=%0d cnt=%0d want 1/24", state_o, cnt_val); end
      $display("[TB] expiry/hold/restart: state=%0d count=%0d", state_o, cnt_val);
   endtask

   task automatic test_priority;
      step(0, 0, 1, 0, 0);
      tests_run++; if (state_o !== 3'd1 || load !== 1'b1) begin tests_failed++; $display("FAIL full_in_run: got state=%0d load=%b want 1/1", state_o, load); end
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      tests_run++; if (state_o !== 3'd0 || load !== 1'b1) begin tests_failed++; $display("FAIL full_in_pause: got state=%0d load=%b want 0/1", state_o, load); end
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      tests_run++; if (state_o !== 3'd0) begin tests_failed++; $display("FAIL idle_pause: got %0d want 0", state_o); end
      step(1, 1, 0, 0, 0);
      tests_run++; if (state_o !== 3'd1) begin tests_failed++; $display("FAIL start_over_pause: got %0d want 1", state_o); end
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      repeat (14) run_tick(1, "to00b");
      tests_run++; if (state_o !== 3'd3) begin tests_failed++; $display("FAIL expire_b: got %0d want 3", state_o); end
      repeat (3) begin step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 0); end
      step(0, 0, 0, 0, 1);
      tests_run++; if (state_o !== 3'd4 || blank !== 1'b1) begin tests_failed++; $display("FAIL hold_b: got state=%0d blank=%b want 4/1", state_o, blank); end
      step(1, 0, 1, 0, 0);
      tests_run++; if (state_o !== 3'd0 || load !== 1'b1 || {preset_s1, preset_s0} !== 8'h24) begin tests_failed++; $display("FAIL full_over_start: got state=%0d load=%b preset=%h want 0/1/24", state_o, load, {preset_s1, preset_s0}); end
      tests_run++; if (horn !== 1'b0 || blank !== 1'b0) begin tests_failed++; $display("FAIL full_over_start_outs: got horn=%b blank=%b want 0/0", horn, blank); end
      step(0, 0, 0, 0, 0);
      $display("[TB] priority: state=%0d count=%0d", state_o, cnt_val);
   endtask

   task automatic test_async_reset;
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      repeat (14) run_tick(1, "to00c");
      tests_run++; if (state_o !== 3'd3 || horn !== 1'b1) begin tests_failed++; $display("FAIL pre_reset: got state=%0d horn=%b want 3/1", state_o, horn); end
      #2 rst_n = 0;
      #1;
      tests_run++; if (horn !== 1'b0 || state_o !== 3'd0 || load !== 1'b0) begin tests_failed++; $display("FAIL async_reset: got horn=%b state=%0d load=%b want 0/0/0", horn, state_o, load); end
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      tests_run++; if (load !== 1'b1 || state_o !== 3'd0) begin tests_failed++; $display("FAIL reinit: got load=%b state=%0d want 1/0", load, state_o); end
      $display("[TB] async reset: horn=%b state=%0d", horn, state_o);
   endtask

   initial begin
      test_reset();
      test_run();
      test_pause();
      test_short_with_tick();
      test_expiry();
      test_priority();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
